// File: rtl/aes_ks_pkg.sv
// Shared types and constants for the AES-128 inverse-order round-key generator.
package aes_ks_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_e;

  // Word 0 sits in the most significant 32 bits, matching the key byte order.
  typedef logic [0:3][31:0] key_t;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_ks_sbox.sv
// Forward AES S-box, one byte in, one byte out, purely combinational.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_inv_key_sched.sv
// Expands an AES-128 key forward to round 10, then streams round keys 10..0
// by undoing one schedule step per accepted key; only one key is ever stored.
module aes_inv_key_sched #(
  parameter int NR = aes_ks_pkg::NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [127:0] key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         done
);
  import aes_ks_pkg::*;

  localparam logic [3:0] LAST = 4'(NR);

  state_e      state_q, state_d;
  key_t        key_q, key_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;

  logic [31:0] sbox_src, rot, sub, t;
  key_t        fwd, inv;

  // One S-box bank serves both directions: the inverse step needs the
  // recovered w3 (w3^w2) before it can rebuild w0.
  always_comb begin
    sbox_src = (state_q == EMIT) ? (key_q[3] ^ key_q[2]) : key_q[3];
    rot      = {sbox_src[23:0], sbox_src[31:24]};
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (rot[8*g +: 8]),
      .out_byte (sub[8*g +: 8])
    );
  end

  always_comb begin
    t      = sub ^ {rcon(cnt_q), 24'h0};
    fwd[0] = key_q[0] ^ t;
    fwd[1] = key_q[1] ^ fwd[0];
    fwd[2] = key_q[2] ^ fwd[1];
    fwd[3] = key_q[3] ^ fwd[2];
    inv[3] = key_q[3] ^ key_q[2];
    inv[2] = key_q[2] ^ key_q[1];
    inv[1] = key_q[1] ^ key_q[0];
    inv[0] = key_q[0] ^ t;
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld) begin
          key_d   = key;
          cnt_d   = 4'd1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        key_d = fwd;
        if (cnt_q == LAST) state_d = EMIT;
        else               cnt_d   = cnt_q + 4'd1;
      end
      EMIT: begin
        if (rk_ready) begin
          if (cnt_q != 4'd0) begin
            key_d = inv;
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign rk_valid = (state_q == EMIT);
  assign rk       = key_q;
  assign rk_idx   = cnt_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched using FIPS-197 key schedules.
module tb_aes_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst, ld, rk_ready;
  logic [127:0] key;
  logic         busy, rk_valid, done;
  logic [127:0] rk;
  logic [3:0]   rk_idx;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] KA   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KC   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KC10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic [127:0] a1 [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  aes_inv_key_sched dut (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld),
    .key      (key),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk       (rk),
    .rk_idx   (rk_idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; ld is sampled at the next rising edge (E0).
  task automatic load(input logic [127:0] k, input bit noisy, input logic [127:0] exp10);
    ld = 1'b1; key = k;
    @(negedge clk);
    ld = 1'b0; key = '0;
    chk1("ld_busy", busy, 1'b1);
    chk1("ld_valid", rk_valid, 1'b0);
    chk1("ld_done", done, 1'b0);
    for (int n = 1; n <= 10; n++) begin
      if (noisy && n == 4) begin ld = 1'b1; key = ~k; end
      @(negedge clk);
      ld = 1'b0;
      chk1("exp_done", done, 1'b0);
      if (n < 10) chk1("exp_valid", rk_valid, 1'b0);
    end
    chk1("first_valid", rk_valid, 1'b1);
    chk4("first_idx", rk_idx, 4'd10);
    chk128("first_rk", rk, exp10);
  endtask

  // Consumes the full KA stream; a withheld ready re-checks the same key next cycle.
  task automatic drain(input bit rnd, input bit stall4, input bit noisy);
    int idx = 10;
    int stall = 0;
    bit rdy;
    bit fin = 1'b0;
    for (int it = 0; it < 300 && !fin; it++) begin
      chk1("emit_valid", rk_valid, 1'b1);
      chk4("emit_idx", rk_idx, 4'(idx));
      chk128("emit_rk", rk, a1[idx]);
      chk1("emit_done", done, 1'b0);
      if (stall4 && idx == 4 && stall < 5) begin rdy = 1'b0; stall++; end
      else if (rnd) rdy = 1'($urandom_range(0, 1));
      else rdy = 1'b1;
      if (noisy && idx == 7) begin ld = 1'b1; key = KC; end
      rk_ready = rdy;
      @(negedge clk);
      ld = 1'b0; rk_ready = 1'b0;
      if (rdy) begin
        if (idx == 0) begin
          chk1("end_done", done, 1'b1);
          chk1("end_busy", busy, 1'b0);
          chk1("end_valid", rk_valid, 1'b0);
          chk128("end_rk", rk, a1[0]);
          chk4("end_idx", rk_idx, 4'd0);
          fin = 1'b1;
        end else begin
          idx--;
        end
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout: got idx %0d want stream end", idx);
    end
  endtask

  initial begin
    rst = 1'b1; ld = 1'b0; key = '0; rk_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_valid", rk_valid, 1'b0);
    chk128("rst_rk", rk, 128'h0);
    chk4("rst_idx", rk_idx, 4'd0);
    chk1("rst_done", done, 1'b0);
    rst = 1'b0;

    // Full stream, then back-to-back restart in the done cycle
    load(KA, 1'b0, a1[10]);
    drain(1'b0, 1'b0, 1'b0);
    load(KA, 1'b0, a1[10]);
    drain(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk1("done_single", done, 1'b0);

    // Random backpressure with a 5-cycle stall at round 4
    load(KA, 1'b0, a1[10]);
    drain(1'b1, 1'b1, 1'b0);
    @(negedge clk);

    // Loads during EXPAND and EMIT are ignored
    load(KA, 1'b1, a1[10]);
    drain(1'b0, 1'b0, 1'b1);
    @(negedge clk);

    // Reset mid-stream, with a simultaneous ld that must be dropped
    load(KA, 1'b0, a1[10]);
    rk_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk4("pre_rst_idx", rk_idx, 4'd6);
    rst = 1'b1; ld = 1'b1; key = KC;
    @(negedge clk);
    rst = 1'b0; ld = 1'b0; key = '0; rk_ready = 1'b0;
    chk1("mrst_busy", busy, 1'b0);
    chk1("mrst_valid", rk_valid, 1'b0);
    chk128("mrst_rk", rk, 128'h0);
    chk4("mrst_idx", rk_idx, 4'd0);
    chk1("mrst_done", done, 1'b0);
    @(negedge clk);
    chk1("mrst_ld_dropped", busy, 1'b0);

    load(KC, 1'b0, KC10);
    rk_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk4("c1_idx0", rk_idx, 4'd0);
    chk128("c1_rk0", rk, KC);
    chk1("c1_done_pre", done, 1'b0);
    @(negedge clk);
    rk_ready = 1'b0;
    chk1("c1_done", done, 1'b1);
    chk1("c1_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_sched.md
# aes_inv_key_sched

Reverse-order AES-128 round-key generator for the decryption datapath paired with `aes_cipher_top`. It accepts a cipher key and expands it forward, one round per cycle, to round key 10. It then streams round keys 10 down to 0 over a valid/ready handshake, deriving each earlier key on the fly. Only one 128-bit key register is held; the full schedule is never stored.

## Interface
- `NR`, default 10. Number of rounds. Only 10 is legal (AES-128).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `ld` in 1: load request. Sampled only in IDLE.
- `key` in 128: cipher key. Bit 127 is the first key byte (w0 MSB).
- `busy` out 1: high in EXPAND and EMIT.
- `rk_valid` out 1: round key on `rk` is valid.
- `rk_ready` in 1: consumer accepts `rk`.
- `rk` out 128: current round key.
- `rk_idx` out 4: round index of `rk`, from 10 down to 0.
- `done` out 1: one-cycle pulse after round key 0 is accepted.

## Operation
- States are IDLE, EXPAND and EMIT. Reset state is IDLE.
- Reset values: `busy`=0, `rk_valid`=0, `rk`=0, `rk_idx`=0, `done`=0. The internal round counter resets to 0.
- **IDLE:** when `ld`=1, register `key` into the key register, set the counter to 1 and go to EXPAND. `ld` in any other state is ignored.
- **EXPAND:** each cycle applies one forward step to the key register (w0..w3), using counter value i:
  - t = SubWord(RotWord(w3)) ^ {rcon[i], 24'h0}
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'
  - The counter increments. After the step with i=10, go to EMIT with `rk_idx`=10.
- **EMIT:** `rk_valid`=1 and `rk` is the key register. On handshake (`rk_valid`&&`rk_ready`):
  - If `rk_idx`>0, apply the inverse step with i=`rk_idx`:
    - w3'=w3^w2, w2'=w2^w1, w1'=w1^w0
    - w0'=w0^SubWord(RotWord(w3'))^{rcon[i],24'h0}
    - Decrement `rk_idx`.
  - If `rk_idx`=0, go to IDLE, pulse `done`, and leave `rk` holding round key 0.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- A single set of four S-boxes is shared by both phases. The S-box input is muxed between w3 (forward step) and w3^w2 (inverse step).
- **Backpressure:** while `rk_valid`=1 and `rk_ready`=0, `rk` and `rk_idx` are held stable.
- **Reset mid-operation:** `rst` aborts immediately. All outputs return to reset values on the next edge.
- **Simultaneous `rst` and `ld`:** `rst` wins and the load is discarded.

## Timing
- If `ld` is sampled at edge E0, EXPAND runs for edges E1 through E10. `rk_valid` is high starting after E10, so the first round key appears 10 cycles after the load edge.
- With `rk_ready` held high, one key is emitted per cycle. Eleven keys take 11 cycles.
- `done` is high for exactly the cycle after the edge that accepts round key 0. `busy` is low in that same cycle, so a new `ld` can be sampled then.
- There is no combinational path from `rk_ready` to `rk_valid` or to `rk`.
- Worst-case combinational path per cycle: XOR, then S-box, then XOR chain.

## Structure
- Shared package `aes_ks_pkg` holds:
  - localparam `NR`=10
  - the state enum typedef (IDLE, EXPAND, EMIT)
  - the `rcon` lookup function
  - the `key_t` typedef (128-bit, four 32-bit words)
- One sub-module, `aes_sbox`: the existing forward 8-bit S-box, instantiated four times for SubWord.
- The top level contains the FSM, the counter, the key register and both step functions. Expected size is about 200 lines.

## Test plan
- **FIPS-197 A.1 full stream:** `ld` with `key`=2b7e151628aed2a6abf7158809cf4f3c and `rk_ready`=1.
  - First output: `rk_idx`=10, `rk`=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `rk_idx`=1: `rk`=a0fafe1788542cb123a339392a6c7605.
  - `rk_idx`=0: `rk`=2b7e…4f3c.
  - `done` pulses once.
- **Latency:** `ld` at edge E0 gives `rk_valid`=0 through E10, then `rk_valid`=1 with `rk_idx`=10 after E10. `busy` is high from E1.
- **Backpressure:** `rk_ready` is toggled randomly (including a 5-cycle stall at `rk_idx`=4). `rk` and `rk_idx` stay stable during stalls and the emitted sequence matches the first scenario exactly.
- **Ignored load:** a second `ld` with a different key during EXPAND and again during EMIT leaves the output sequence identical to the first scenario.
- **Mid-operation reset:**
  - `rst` pulsed at `rk_idx`=6: after the next edge all outputs are 0 and the state is IDLE.
  - A following `ld` with `key`=000102030405060708090a0b0c0d0e0f produces round key 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- **Back-to-back:** `ld` is asserted in the same cycle `done`=1. A new stream of 11 keys follows, with no extra `done` pulses.
